// File: rtl/serial_add_seq_pkg.sv
// rtl/serial_add_seq_pkg.sv - FSM state and op-select encodings shared by the bit-serial adder sequencer
package serial_add_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/FullAdder.sv
// rtl/FullAdder.sv - 1-bit full-adder cell shared by the serial sequencer
module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic FaS,
    output logic FaC
);

    assign FaS = A ^ B ^ Cin;
    assign FaC = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial add/subtract sequencer, one full-adder cell over WIDTH cycles
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, psum_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, ovf_q;
    logic             fa_s, fa_c;
    logic             last_step;

    FullAdder u_fa (
        .A   (opa_q[0]),
        .B   (opb_q[0]),
        .Cin (carry_q),
        .FaS (fa_s),
        .FaC (fa_c)
    );

    assign last_step = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Subtract is A + ~B + 1: invert B at capture and force the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= (op_sub == OP_SUB) ? ~b : b;
                        carry_q <= (op_sub == OP_SUB) ? 1'b1 : cin;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    psum_q  <= {fa_s, psum_q[WIDTH-1:1]};
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    carry_q <= fa_c;
                    if (last_step) begin
                        // carry_q here is still the carry into the MSB
                        sum_q  <= {fa_s, psum_q[WIDTH-1:1]};
                        cout_q <= fa_c;
                        ovf_q  <= carry_q ^ fa_c;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - scoreboard bench for the bit-serial add/subtract sequencer
module tb_serial_add_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    logic [W-1:0] last_sum = '0;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        logic [W:0] t;
        res_t       r;
        if (s) t = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else   t = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        r.sum  = t[W-1:0];
        r.cout = t[W];
        if (s) r.ovf = (x[W-1] != y[W-1]) && (r.sum[W-1] != x[W-1]);
        else   r.ovf = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("sum",  32'(sum),  32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("ovf",  32'(ovf),  32'(e.ovf));
            end
        end
    end

    task automatic scramble_inputs();
        a      = W'($urandom);
        b      = W'($urandom);
        cin    = 1'($urandom);
        op_sub = 1'($urandom);
    endtask

    // mode 0: plain, 1: start collisions in RUN and DONE, 2: reset on RUN cycle 4
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic ts, input int mode);
        res_t e;
        int   lat;
        int   nbusy;
        logic [W-1:0] prev;
        prev = last_sum;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; op_sub = ts; start = 1'b1;
        e = model(ta, tb_v, tc, ts);
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        lat = 0;
        nbusy = 0;
        while (!done && lat < 4*W) begin
            if (busy) nbusy++;
            if (lat == 1) check("sum_hold", 32'(sum), 32'(prev));
            if (mode == 1 && lat == 2) begin
                start = 1'b1;
                scramble_inputs();
            end else if (mode == 1 && lat == 3) begin
                start = 1'b0;
            end
            if (mode == 2 && lat == 3) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_sum",  32'(sum),  32'd0);
                check("rst_cout", 32'(cout), 32'd0);
                check("rst_ovf",  32'(ovf),  32'd0);
                void'(exp_q.pop_back());
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (W + 3) @(negedge clk);
                check("abort_no_done", 32'(done), 32'd0);
                last_sum = '0;
                return;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(W));
        check("busy_cycles", 32'(nbusy), 32'(W));
        last_sum = e.sum;
        if (mode == 1) begin
            start = 1'b1;
            scramble_inputs();
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("done_width", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("no_reaccept", 32'(busy), 32'd0);
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op(8'h35, 8'h4A, 1'b0, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0, 0);
        do_op(8'h10, 8'h20, 1'b0, 1'b1, 0);
        do_op(8'h80, 8'h01, 1'b0, 1'b1, 0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        do_op(8'h5A, 8'h3C, 1'b1, 1'b0, 1);
        do_op(8'hC3, 8'h7E, 1'b0, 1'b1, 2);
        do_op(8'h12, 8'h34, 1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        repeat (4) @(negedge clk);
        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
